// File: rtl/llc_cache_pkg.sv
// Shared types and geometry for the last-level cache model: address split,
// bus/snoop/L1 message encodings, MESI line state and the per-set line array.
package llc_defs;
  localparam int NUM_SETS      = 16384;
  localparam int ASSOCIATIVITY = 16;
  localparam int TAG_BITS      = 12;
  localparam int INDEX_BITS    = 14;
  localparam int OFFSET_BITS   = 6;
  localparam int WAY_BITS      = 4;
  localparam int PLRU_BITS     = ASSOCIATIVITY - 1;
  localparam int COUNT_MAX     = 32'h7fff_ffff;

  typedef enum logic [2:0] {NOOP, READ, WRITE, INVALIDATE, RWIM} busOperation;
  typedef enum logic [1:0] {NOHIT, HIT, HITM} snoopResults;
  typedef enum logic [2:0] {NOMSG, GETLINE, SENDLINE, INVALIDATELINE, EVICTLINE} messages;
  typedef enum logic [1:0] {I, S, E, M} mesi_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    mesi_t               mesi;
  } cache_line_t;

  typedef cache_line_t [ASSOCIATIVITY-1:0] cache_set_t;
  typedef logic [WAY_BITS-1:0] way_t;

  function automatic int sat_inc(input int c);
    return (c >= COUNT_MAX) ? c : c + 1;
  endfunction

  // Other caches' response to our own bus ops is encoded in the low address bits.
  function automatic snoopResults snoop_of(input logic [1:0] a);
    case (a)
      2'b00:   return HIT;
      2'b01:   return HITM;
      default: return NOHIT;
    endcase
  endfunction
endpackage

// File: rtl/llc_cache_if.sv
// Trace-driver side of the LLC: request (addr/op) in, counters, bus/snoop/L1
// results and the full line array out.
interface llc_cache_if;
  import llc_defs::*;

  logic [31:0]  addr;
  int           op;
  int           cacheRds;
  int           cacheWrs;
  int           cacheHits;
  int           cacheMisses;
  busOperation  busOp;
  snoopResults  snoopResult;
  messages      message;
  cache_set_t   LLC_cache [NUM_SETS];

  modport master (
    output addr, op,
    input  cacheRds, cacheWrs, cacheHits, cacheMisses,
    input  busOp, snoopResult, message, LLC_cache
  );

  modport slave (
    input  addr, op,
    output cacheRds, cacheWrs, cacheHits, cacheMisses,
    output busOp, snoopResult, message, LLC_cache
  );
endinterface

// File: rtl/llc_plru.sv
// Combinational 16-way tree pseudo-LRU: picks the fill victim and computes the
// tree bits after touching either the hit way or that victim.
module llc_plru
  import llc_defs::*;
(
  input  logic [PLRU_BITS-1:0]     tree,
  input  logic                     hit,
  input  way_t                     hit_way,
  input  logic [ASSOCIATIVITY-1:0] live,
  output way_t                     victim,
  output logic [PLRU_BITS-1:0]     next_tree
);
  logic       found;
  logic [3:0] node;
  way_t       used;

  // NOTE: every output and temporary gets a default at the top so no path
  // through this block leaves a value held, which would infer a latch.
  always_comb begin
    victim    = '0;
    found     = 1'b0;
    node      = '0;
    next_tree = tree;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (!live[w] && !found) begin
        victim = WAY_BITS'(w);
        found  = 1'b1;
      end
    end
    // All ways live: walk the tree, bit 0 steering left toward lower ways.
    if (!found) begin
      for (int l = 0; l < WAY_BITS; l++) begin
        victim[WAY_BITS-1-l] = tree[node];
        node = {node[2:0], 1'b0} + 4'd1 + {3'b000, tree[node]};
      end
    end

    used = hit ? hit_way : victim;
    node = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      next_tree[node] = ~used[WAY_BITS-1-l];
      node = {node[2:0], 1'b0} + 4'd1 + {3'b000, used[WAY_BITS-1-l]};
    end
  end
endmodule

// File: rtl/llc_cache.sv
// 16-way set-associative LLC with MESI states: one trace op per clock, updates
// line state, PLRU and counters, and reports bus op, snoop result and L1 message.
module llc_cache
  import llc_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  llc_cache_if.slave  bus
);
  logic [INDEX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]      line_tag;
  cache_set_t               cur_set;
  logic                     hit;
  way_t                     hit_way;
  mesi_t                    hit_mesi;
  logic [ASSOCIATIVITY-1:0] live;
  way_t                     victim;
  logic [PLRU_BITS-1:0]     next_tree;
  snoopResults              snoop_in;
  logic                     clear;
  logic                     unused_offset;
  logic [PLRU_BITS-1:0]     plru [NUM_SETS];

  assign idx           = bus.addr[OFFSET_BITS +: INDEX_BITS];
  assign line_tag      = bus.addr[31 -: TAG_BITS];
  assign cur_set       = bus.LLC_cache[idx];
  assign snoop_in      = snoop_of(bus.addr[1:0]);
  assign clear         = rst || (bus.op == 8);
  assign unused_offset = ^bus.addr[5:2];
  assign hit_mesi      = cur_set[hit_way].mesi;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    live    = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      live[w] = cur_set[w].valid && (cur_set[w].mesi != I);
      if (live[w] && (cur_set[w].tag == line_tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  llc_plru u_plru (
    .tree      (plru[idx]),
    .hit       (hit),
    .hit_way   (hit_way),
    .live      (live),
    .victim    (victim),
    .next_tree (next_tree)
  );

  // NOTE: state is updated with non-blocking assignments only, so every read
  // in this block sees the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      // NOTE: the line array and PLRU are wiped here on purpose: reset and the
      // clear op must both leave every line invalid, not just the control state.
      for (int s = 0; s < NUM_SETS; s++) begin
        bus.LLC_cache[s] <= '0;
        plru[s]          <= '0;
      end
      bus.cacheRds    <= 0;
      bus.cacheWrs    <= 0;
      bus.cacheHits   <= 0;
      bus.cacheMisses <= 0;
      bus.busOp       <= NOOP;
      bus.snoopResult <= NOHIT;
      bus.message     <= NOMSG;
    end else begin
      bus.busOp       <= NOOP;
      bus.snoopResult <= NOHIT;
      bus.message     <= NOMSG;
      case (bus.op)
        0, 2: begin
          bus.cacheRds <= sat_inc(bus.cacheRds);
          bus.message  <= SENDLINE;
          plru[idx]    <= next_tree;
          if (hit) begin
            bus.cacheHits <= sat_inc(bus.cacheHits);
          end else begin
            bus.cacheMisses           <= sat_inc(bus.cacheMisses);
            bus.LLC_cache[idx][victim] <= '{valid: 1'b1, tag: line_tag,
                                            mesi: (snoop_in == NOHIT) ? E : S};
            bus.busOp                 <= READ;
            bus.snoopResult           <= snoop_in;
          end
        end
        1: begin
          bus.cacheWrs <= sat_inc(bus.cacheWrs);
          bus.message  <= SENDLINE;
          plru[idx]    <= next_tree;
          if (hit) begin
            bus.cacheHits                    <= sat_inc(bus.cacheHits);
            bus.LLC_cache[idx][hit_way].mesi <= M;
            if (hit_mesi == S) begin
              bus.busOp       <= INVALIDATE;
              bus.snoopResult <= snoop_in;
            end
          end else begin
            bus.cacheMisses            <= sat_inc(bus.cacheMisses);
            bus.LLC_cache[idx][victim] <= '{valid: 1'b1, tag: line_tag, mesi: M};
            bus.busOp                  <= RWIM;
            bus.snoopResult            <= snoop_in;
          end
        end
        3: begin
          bus.busOp <= READ;
          if (hit) begin
            bus.snoopResult                  <= (hit_mesi == M) ? HITM : HIT;
            bus.message                      <= (hit_mesi == M) ? GETLINE : NOMSG;
            bus.LLC_cache[idx][hit_way].mesi <= S;
          end
        end
        4: bus.busOp <= WRITE;
        5: begin
          bus.busOp <= RWIM;
          if (hit) begin
            bus.snoopResult                   <= (hit_mesi == M) ? HITM : HIT;
            bus.message                       <= (hit_mesi == M) ? EVICTLINE : INVALIDATELINE;
            bus.LLC_cache[idx][hit_way].valid <= 1'b0;
            bus.LLC_cache[idx][hit_way].mesi  <= I;
          end
        end
        6: begin
          bus.busOp <= INVALIDATE;
          if (hit && (hit_mesi == S)) begin
            bus.snoopResult                   <= HIT;
            bus.message                       <= INVALIDATELINE;
            bus.LLC_cache[idx][hit_way].valid <= 1'b0;
            bus.LLC_cache[idx][hit_way].mesi  <= I;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_llc_cache.sv
// Directed bench for llc_cache: a table of single-op vectors with expected
// outputs, counters and line state, then eviction/PLRU, clear and reset sequences.
module tb_llc_cache;
  import llc_defs::*;

  logic clk = 1'b0;
  logic rst;
  llc_cache_if bus ();

  llc_cache dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          op;
    logic [31:0] addr;
    busOperation bus_op;
    snoopResults snoop;
    messages     msg;
    mesi_t       mesi;
    int          rds, wrs, hits, misses;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int op, input logic [31:0] a);
    @(negedge clk);
    bus.op   = op;
    bus.addr = a;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] outs();
    return 128'({bus.busOp, bus.snoopResult, bus.message});
  endfunction

  function automatic logic [127:0] exp_outs(input busOperation b, input snoopResults s, input messages m);
    return 128'({b, s, m});
  endfunction

  function automatic logic [127:0] cnts();
    return {bus.cacheRds, bus.cacheWrs, bus.cacheHits, bus.cacheMisses};
  endfunction

  function automatic logic [127:0] exp_cnts(input int r, input int w, input int h, input int m);
    return {r, w, h, m};
  endfunction

  function automatic logic [127:0] line_state(input int set, input int way);
    return 128'({bus.LLC_cache[set][way].valid, bus.LLC_cache[set][way].mesi});
  endfunction

  function automatic logic [127:0] exp_state(input mesi_t st);
    return 128'({st != I, st});
  endfunction

  function automatic logic [127:0] line_full(input int set, input int way);
    return 128'(bus.LLC_cache[set][way]);
  endfunction

  function automatic logic [127:0] exp_full(input logic [11:0] t, input mesi_t st);
    return 128'({st != I, t, st});
  endfunction

  initial begin
    //          op  addr          busOp       snoop  message         mesi rds wrs hit miss
    vecs[0]  = '{0, 32'h10019D94, READ,       HIT,   SENDLINE,       S,   1, 0, 0, 1};
    vecs[1]  = '{0, 32'h00000002, READ,       NOHIT, SENDLINE,       E,   2, 0, 0, 2};
    vecs[2]  = '{1, 32'h00000002, NOOP,       NOHIT, SENDLINE,       M,   2, 1, 1, 2};
    vecs[3]  = '{3, 32'h00000002, READ,       HITM,  GETLINE,        S,   2, 1, 1, 2};
    vecs[4]  = '{1, 32'h00000002, INVALIDATE, NOHIT, SENDLINE,       M,   2, 2, 2, 2};
    vecs[5]  = '{4, 32'h00000002, WRITE,      NOHIT, NOMSG,          M,   2, 2, 2, 2};
    vecs[6]  = '{7, 32'h00000002, NOOP,       NOHIT, NOMSG,          M,   2, 2, 2, 2};
    vecs[7]  = '{9, 32'h00000002, NOOP,       NOHIT, NOMSG,          M,   2, 2, 2, 2};
    vecs[8]  = '{5, 32'h00000002, RWIM,       HITM,  EVICTLINE,      I,   2, 2, 2, 2};
    vecs[9]  = '{2, 32'h00000001, READ,       HITM,  SENDLINE,       S,   3, 2, 2, 3};
    vecs[10] = '{6, 32'h00000001, INVALIDATE, HIT,   INVALIDATELINE, I,   3, 2, 2, 3};
    vecs[11] = '{6, 32'h00000001, INVALIDATE, NOHIT, NOMSG,          I,   3, 2, 2, 3};
    vecs[12] = '{1, 32'h00000003, RWIM,       NOHIT, SENDLINE,       M,   3, 3, 2, 4};
    vecs[13] = '{3, 32'h00100003, READ,       NOHIT, NOMSG,          M,   3, 3, 2, 4};
    vecs[14] = '{6, 32'h00000003, INVALIDATE, NOHIT, NOMSG,          M,   3, 3, 2, 4};
    vecs[15] = '{0, 32'h00040042, READ,       NOHIT, SENDLINE,       E,   4, 3, 2, 5};
    vecs[16] = '{3, 32'h00040042, READ,       HIT,   NOMSG,          S,   4, 3, 2, 5};
    vecs[17] = '{5, 32'h00040040, RWIM,       HIT,   INVALIDATELINE, I,   4, 3, 2, 5};

    rst      = 1'b1;
    bus.op   = 9;
    bus.addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outs", outs(), exp_outs(NOOP, NOHIT, NOMSG));
    check("reset counters", cnts(), exp_cnts(0, 0, 0, 0));
    check("reset line", line_full(32'h676, 0), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Every table line targets way 0 of its set (sets start empty or that way was freed).
    for (int v = 0; v < 18; v++) begin
      step(vecs[v].op, vecs[v].addr);
      check($sformatf("vec%0d outs", v), outs(),
            exp_outs(vecs[v].bus_op, vecs[v].snoop, vecs[v].msg));
      check($sformatf("vec%0d counters", v), cnts(),
            exp_cnts(vecs[v].rds, vecs[v].wrs, vecs[v].hits, vecs[v].misses));
      check($sformatf("vec%0d line", v), line_state(int'(vecs[v].addr[19:6]), 0),
            exp_state(vecs[v].mesi));
    end

    step(8, 32'h0);
    check("clear outs", outs(), exp_outs(NOOP, NOHIT, NOMSG));
    check("clear counters", cnts(), exp_cnts(0, 0, 0, 0));
    check("clear line 676", line_state(32'h676, 0), exp_state(I));
    check("clear line 0", line_state(0, 0), exp_state(I));

    // Fill all 16 ways of set 0, then a 17th tag must displace way 0.
    for (int t = 0; t < 17; t++) step(0, (32'(t) << 20) | 32'h2);
    check("evict way0", line_full(0, 0), exp_full(12'd16, E));
    check("evict way1", line_full(0, 1), exp_full(12'd1, E));
    check("evict way15", line_full(0, 15), exp_full(12'd15, E));
    check("evict counters", cnts(), exp_cnts(17, 0, 0, 17));

    // After touching way 0 the tree points right at root and left below: way 8.
    step(0, (32'd17 << 20) | 32'h2);
    check("plru victim way8", line_full(0, 8), exp_full(12'd17, E));
    check("plru keeps way0", line_full(0, 0), exp_full(12'd16, E));
    step(0, (32'd1 << 20) | 32'h2);
    check("hit after evict outs", outs(), exp_outs(NOOP, NOHIT, SENDLINE));
    check("hit after evict counters", cnts(), exp_cnts(19, 0, 1, 18));

    // Reset wins over a write presented in the same cycle.
    @(negedge clk);
    rst      = 1'b1;
    bus.op   = 1;
    bus.addr = 32'h0000_0002;
    @(posedge clk);
    #1;
    check("rst prio counters", cnts(), exp_cnts(0, 0, 0, 0));
    check("rst prio outs", outs(), exp_outs(NOOP, NOHIT, NOMSG));
    check("rst prio line", line_state(0, 8), exp_state(I));
    @(negedge clk);
    rst    = 1'b0;
    bus.op = 9;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
